// File: rtl/pipe_core.sv
// Five-stage MIPS-subset pipeline core (IF/ID/EX/MEM/WB) with forwarding,
// load-use / dependency stalls and branch/jump redirect. Memories are external.
module pipe_core #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter bit          FORWARD  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_data,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  output logic            dmem_re,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_we,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            flush
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Fetch state
  logic [31:0]     pc_q;
  logic [31:0]     pc_plus4;

  // IF/ID
  logic [31:0]     ifid_instr;
  logic [31:0]     ifid_pc4;

  // ID/EX
  logic            idex_wr;
  logic [4:0]      idex_dest;
  logic            idex_mr;
  logic            idex_mw;
  logic            idex_br;
  logic [2:0]      idex_alu;
  logic            idex_imm_sel;
  logic [4:0]      idex_rs;
  logic [4:0]      idex_rt;
  logic [XLEN-1:0] idex_rs_val;
  logic [XLEN-1:0] idex_rt_val;
  logic [15:0]     idex_imm;
  logic [31:0]     idex_pc4;

  // EX/MEM
  logic            exmem_wr;
  logic [4:0]      exmem_dest;
  logic            exmem_mr;
  logic            exmem_mw;
  logic [XLEN-1:0] exmem_alu;
  logic [XLEN-1:0] exmem_st;

  // MEM/WB
  logic            memwb_we;
  logic [4:0]      memwb_reg;
  logic [XLEN-1:0] memwb_data;

  logic [XLEN-1:0] regs [32];
  logic            wb_we_i;

  // ---------------------------------------------------------------- ID
  logic [5:0]      id_op;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic [4:0]      id_rd;
  logic [5:0]      id_funct;
  logic [15:0]     id_imm;
  logic            id_wr;
  logic [4:0]      id_dest;
  logic            id_mr;
  logic            id_mw;
  logic            id_br;
  logic            id_jmp;
  logic [2:0]      id_alu;
  logic            id_imm_sel;
  logic            id_reads_rs;
  logic            id_reads_rt;
  logic [XLEN-1:0] id_rs_val;
  logic [XLEN-1:0] id_rt_val;
  logic [31:0]     id_jtarget;

  assign id_op    = ifid_instr[31:26];
  assign id_rs    = ifid_instr[25:21];
  assign id_rt    = ifid_instr[20:16];
  assign id_rd    = ifid_instr[15:11];
  assign id_funct = ifid_instr[5:0];
  assign id_imm   = ifid_instr[15:0];

  assign id_reads_rs = (id_op != OP_J);
  assign id_reads_rt = (id_op == OP_R) || (id_op == OP_BEQ) || (id_op == OP_SW);
  assign id_jtarget  = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

  always_comb begin
    id_wr      = 1'b0;
    id_dest    = 5'd0;
    id_mr      = 1'b0;
    id_mw      = 1'b0;
    id_br      = 1'b0;
    id_jmp     = 1'b0;
    id_alu     = ALU_ADD;
    id_imm_sel = 1'b0;
    case (id_op)
      OP_R: begin
        id_dest = id_rd;
        case (id_funct)
          FN_ADD: begin id_wr = (id_rd != 5'd0); id_alu = ALU_ADD; end
          FN_SUB: begin id_wr = (id_rd != 5'd0); id_alu = ALU_SUB; end
          FN_AND: begin id_wr = (id_rd != 5'd0); id_alu = ALU_AND; end
          FN_OR:  begin id_wr = (id_rd != 5'd0); id_alu = ALU_OR;  end
          FN_SLT: begin id_wr = (id_rd != 5'd0); id_alu = ALU_SLT; end
          default: id_dest = 5'd0;
        endcase
      end
      OP_ADDI: begin
        id_wr      = (id_rt != 5'd0);
        id_dest    = id_rt;
        id_imm_sel = 1'b1;
      end
      OP_LW: begin
        id_wr      = (id_rt != 5'd0);
        id_dest    = id_rt;
        id_mr      = 1'b1;
        id_imm_sel = 1'b1;
      end
      OP_SW: begin
        id_mw      = 1'b1;
        id_imm_sel = 1'b1;
      end
      OP_BEQ:  id_br  = 1'b1;
      OP_J:    id_jmp = 1'b1;
      default: ;
    endcase
  end

  // Register read with same-cycle WB bypass; $0 is hard-wired to zero.
  assign id_rs_val = (id_rs == 5'd0) ? '0 :
                     (wb_we_i && (memwb_reg == id_rs)) ? memwb_data : regs[id_rs];
  assign id_rt_val = (id_rt == 5'd0) ? '0 :
                     (wb_we_i && (memwb_reg == id_rt)) ? memwb_data : regs[id_rt];

  // ---------------------------------------------------------------- hazards
  logic hit_idex;
  logic hit_exmem;
  logic load_use;
  logic dep_stall;
  logic raw_stall;
  logic br_taken;
  logic stall_i;
  logic jump_i;

  assign hit_idex  = idex_wr &&
                     ((id_reads_rs && (id_rs == idex_dest)) ||
                      (id_reads_rt && (id_rt == idex_dest)));
  assign hit_exmem = exmem_wr &&
                     ((id_reads_rs && (id_rs == exmem_dest)) ||
                      (id_reads_rt && (id_rt == exmem_dest)));
  assign load_use  = idex_mr && hit_idex;
  assign dep_stall = hit_idex || hit_exmem;
  assign raw_stall = FORWARD ? load_use : dep_stall;

  // A taken branch squashes whatever sits in ID, so its stall/jump is moot.
  assign stall_i = raw_stall && !br_taken;
  assign jump_i  = id_jmp && !br_taken && !stall_i;

  // ---------------------------------------------------------------- EX
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_op_b;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_res;
  logic [31:0]     ex_btarget;

  always_comb begin
    ex_a = idex_rs_val;
    ex_b = idex_rt_val;
    if (FORWARD) begin
      if (exmem_wr && !exmem_mr && (exmem_dest == idex_rs))
        ex_a = exmem_alu;
      else if (wb_we_i && (memwb_reg == idex_rs))
        ex_a = memwb_data;
      if (exmem_wr && !exmem_mr && (exmem_dest == idex_rt))
        ex_b = exmem_alu;
      else if (wb_we_i && (memwb_reg == idex_rt))
        ex_b = memwb_data;
    end
  end

  assign ex_imm     = XLEN'($signed(idex_imm));
  assign ex_op_b    = idex_imm_sel ? ex_imm : ex_b;
  assign ex_btarget = idex_pc4 + (32'($signed(idex_imm)) << 2);
  assign br_taken   = idex_br && (ex_a == ex_b);

  always_comb begin
    ex_res = '0;
    case (idex_alu)
      ALU_ADD: ex_res = ex_a + ex_op_b;
      ALU_SUB: ex_res = ex_a - ex_op_b;
      ALU_AND: ex_res = ex_a & ex_op_b;
      ALU_OR:  ex_res = ex_a | ex_op_b;
      ALU_SLT: ex_res = XLEN'($signed(ex_a) < $signed(ex_op_b));
      default: ex_res = '0;
    endcase
  end

  // ---------------------------------------------------------------- sequential
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= PC_RESET;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
    end else if (br_taken) begin
      pc_q       <= ex_btarget;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
    end else if (stall_i) begin
      pc_q       <= pc_q;
    end else if (jump_i) begin
      pc_q       <= id_jtarget;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
    end else begin
      pc_q       <= pc_plus4;
      ifid_instr <= imem_data;
      ifid_pc4   <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || br_taken || stall_i) begin
      idex_wr      <= 1'b0;
      idex_dest    <= 5'd0;
      idex_mr      <= 1'b0;
      idex_mw      <= 1'b0;
      idex_br      <= 1'b0;
      idex_alu     <= ALU_ADD;
      idex_imm_sel <= 1'b0;
      idex_rs      <= 5'd0;
      idex_rt      <= 5'd0;
      idex_rs_val  <= '0;
      idex_rt_val  <= '0;
      idex_imm     <= 16'd0;
      idex_pc4     <= 32'd0;
    end else begin
      idex_wr      <= id_wr;
      idex_dest    <= id_dest;
      idex_mr      <= id_mr;
      idex_mw      <= id_mw;
      idex_br      <= id_br;
      idex_alu     <= id_alu;
      idex_imm_sel <= id_imm_sel;
      idex_rs      <= id_rs;
      idex_rt      <= id_rt;
      idex_rs_val  <= id_rs_val;
      idex_rt_val  <= id_rt_val;
      idex_imm     <= id_imm;
      idex_pc4     <= ifid_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_wr   <= 1'b0;
      exmem_dest <= 5'd0;
      exmem_mr   <= 1'b0;
      exmem_mw   <= 1'b0;
      exmem_alu  <= '0;
      exmem_st   <= '0;
      memwb_we   <= 1'b0;
      memwb_reg  <= 5'd0;
      memwb_data <= '0;
    end else begin
      exmem_wr   <= idex_wr;
      exmem_dest <= idex_dest;
      exmem_mr   <= idex_mr;
      exmem_mw   <= idex_mw;
      exmem_alu  <= ex_res;
      exmem_st   <= ex_b;
      memwb_we   <= exmem_wr;
      memwb_reg  <= exmem_dest;
      memwb_data <= exmem_mr ? dmem_rdata : exmem_alu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we_i) begin
      regs[memwb_reg] <= memwb_data;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign wb_we_i    = memwb_we && !rst;
  assign imem_addr  = pc_q;
  assign dmem_addr  = rst ? '0 : exmem_alu;
  assign dmem_wdata = rst ? '0 : exmem_st;
  assign dmem_we    = exmem_mw && !rst;
  assign dmem_re    = exmem_mr && !rst;
  assign wb_we      = wb_we_i;
  assign wb_reg     = rst ? 5'd0 : memwb_reg;
  assign wb_data    = rst ? '0 : memwb_data;
  assign stall      = stall_i && !rst;
  assign flush      = (br_taken || jump_i) && !rst;

endmodule

// File: tb/tb_pipe_core.sv
// Bench for pipe_core: directed hazard programs on a FORWARD=1 and a FORWARD=0
// instance, plus random programs checked against an instruction-level model.
module tb_pipe_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] prog [256];

  logic [31:0] ia_f, id_f, da_f, dw_f, drd_f, wbd_f;
  logic        dwe_f, dre_f, wbwe_f, stl_f, fl_f;
  logic [4:0]  wbr_f;
  logic [31:0] ia_n, id_n, da_n, dw_n, drd_n, wbd_n;
  logic        dwe_n, dre_n, wbwe_n, stl_n, fl_n;
  logic [4:0]  wbr_n;

  pipe_core #(.FORWARD(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .imem_addr(ia_f), .imem_data(id_f),
    .dmem_addr(da_f), .dmem_wdata(dw_f), .dmem_we(dwe_f), .dmem_re(dre_f),
    .dmem_rdata(drd_f), .wb_we(wbwe_f), .wb_reg(wbr_f), .wb_data(wbd_f),
    .stall(stl_f), .flush(fl_f));

  pipe_core #(.FORWARD(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .imem_addr(ia_n), .imem_data(id_n),
    .dmem_addr(da_n), .dmem_wdata(dw_n), .dmem_we(dwe_n), .dmem_re(dre_n),
    .dmem_rdata(drd_n), .wb_we(wbwe_n), .wb_reg(wbr_n), .wb_data(wbd_n),
    .stall(stl_n), .flush(fl_n));

  assign id_f = prog[ia_f[9:2]];
  assign id_n = prog[ia_n[9:2]];

  logic [31:0] dm_f [64];
  logic [31:0] dm_n [64];
  assign drd_f = dm_f[da_f[7:2]];
  assign drd_n = dm_n[da_n[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin dm_f[i] <= 0; dm_n[i] <= 0; end
    end else begin
      if (dwe_f) dm_f[da_f[7:2]] <= dw_f;
      if (dwe_n) dm_n[da_n[7:2]] <= dw_n;
    end
  end

  typedef struct { logic [4:0] r; logic [31:0] d; int c; } wb_ev_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } st_ev_t;

  wb_ev_t wb_f[$], wb_n[$], exp_wb[$];
  st_ev_t st_f[$], st_n[$], exp_st[$];
  int cyc, stall_f_cnt, stall_n_cnt, flush_f_cnt, flush_n_cnt;
  logic [31:0] fetch_f [256];

  always @(negedge clk) begin
    if (rst) begin
      wb_f.delete(); wb_n.delete(); st_f.delete(); st_n.delete();
      cyc = 0; stall_f_cnt = 0; stall_n_cnt = 0; flush_f_cnt = 0; flush_n_cnt = 0;
    end else begin
      if (wbwe_f) wb_f.push_back('{r: wbr_f, d: wbd_f, c: cyc});
      if (wbwe_n) wb_n.push_back('{r: wbr_n, d: wbd_n, c: cyc});
      if (dwe_f) st_f.push_back('{a: da_f, d: dw_f});
      if (dwe_n) st_n.push_back('{a: da_n, d: dw_n});
      if (stl_f) stall_f_cnt++;
      if (stl_n) stall_n_cnt++;
      if (fl_f) flush_f_cnt++;
      if (fl_n) flush_n_cnt++;
      if (cyc < 256) fetch_f[cyc] = ia_f;
      cyc++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'b00000, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'b000010, target[27:2]};
  endfunction

  function automatic logic [31:0] last_wb(input bit nofwd, input logic [4:0] r);
    logic [31:0] v = 32'hDEAD_BEEF;
    if (!nofwd) begin
      foreach (wb_f[k]) if (wb_f[k].r == r) v = wb_f[k].d;
    end else begin
      foreach (wb_n[k]) if (wb_n[k].r == r) v = wb_n[k].d;
    end
    return v;
  endfunction

  function automatic int count_wb(input bit nofwd, input logic [4:0] r);
    int n = 0;
    if (!nofwd) begin
      foreach (wb_f[k]) if (wb_f[k].r == r) n++;
    end else begin
      foreach (wb_n[k]) if (wb_n[k].r == r) n++;
    end
    return n;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  task automatic run(input int n);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: executes the program sequentially until a
  // self-jump and records architectural register writes and stores in order.
  task automatic model_run();
    logic [31:0] mr [32];
    logic [31:0] mm [64];
    logic [31:0] pc, pc4, npc, ins, a, b, res, sx, addr;
    logic [4:0]  dest;
    bit          wr;
    exp_wb.delete(); exp_st.delete();
    for (int i = 0; i < 32; i++) mr[i] = 0;
    for (int i = 0; i < 64; i++) mm[i] = 0;
    pc = 0;
    for (int s = 0; s < 500; s++) begin
      ins = prog[pc[9:2]];
      if (ins == enc_j(pc)) break;
      pc4 = pc + 4; npc = pc4; wr = 0; dest = 0; res = 0;
      a = mr[ins[25:21]]; b = mr[ins[20:16]];
      sx = {{16{ins[15]}}, ins[15:0]};
      case (ins[31:26])
        6'b000000: begin
          dest = ins[15:11]; wr = 1;
          case (ins[5:0])
            6'b100000: res = a + b;
            6'b100010: res = a - b;
            6'b100100: res = a & b;
            6'b100101: res = a | b;
            6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:   wr = 0;
          endcase
        end
        6'b001000: begin dest = ins[20:16]; wr = 1; res = a + sx; end
        6'b100011: begin addr = a + sx; dest = ins[20:16]; wr = 1; res = mm[addr[7:2]]; end
        6'b101011: begin
          addr = a + sx; mm[addr[7:2]] = b;
          exp_st.push_back('{a: addr, d: b});
        end
        6'b000100: if (a == b) npc = pc4 + (sx << 2);
        6'b000010: npc = {pc4[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      if (wr && dest != 0) begin
        mr[dest] = res;
        exp_wb.push_back('{r: dest, d: res, c: 0});
      end
      pc = npc;
    end
  endtask

  task automatic gen_random(input int nr);
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    int k, off, tgt;
    logic [4:0] rs, rt, rd;
    clear_prog();
    for (int i = 0; i < nr; i++) begin
      k  = $urandom_range(0, 9);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      case (k)
        0, 1, 2: prog[i] = enc_r(fn[$urandom_range(0, 4)], rd, rs, rt);
        3, 9:    prog[i] = enc_i(6'b001000, rt, rs, 16'($urandom));
        4:       prog[i] = enc_i(6'b100011, rt, 5'd0, 16'(4 * $urandom_range(0, 15)));
        5:       prog[i] = enc_i(6'b101011, rt, 5'd0, 16'(4 * $urandom_range(0, 15)));
        6: begin
          off = $urandom_range(0, 3);
          if (off > nr - 1 - i) off = nr - 1 - i;
          prog[i] = enc_i(6'b000100, rt, rs, 16'(off));
        end
        7: begin
          tgt = i + 1 + $urandom_range(0, 2);
          if (tgt > nr) tgt = nr;
          prog[i] = enc_j(32'(tgt * 4));
        end
        default: begin
          if ($urandom_range(0, 1) == 1) prog[i] = {6'b111111, 26'($urandom)};
          else prog[i] = {6'b000000, 20'($urandom), 6'b000111};
        end
      endcase
    end
    prog[nr] = enc_j(32'(nr * 4));
  endtask

  task automatic cmp_random(input int t);
    chk($sformatf("rnd%0d_f_wbcount", t), 32'(wb_f.size()), 32'(exp_wb.size()));
    chk($sformatf("rnd%0d_n_wbcount", t), 32'(wb_n.size()), 32'(exp_wb.size()));
    chk($sformatf("rnd%0d_f_stcount", t), 32'(st_f.size()), 32'(exp_st.size()));
    chk($sformatf("rnd%0d_n_stcount", t), 32'(st_n.size()), 32'(exp_st.size()));
    for (int k = 0; k < exp_wb.size(); k++) begin
      if (k < wb_f.size()) begin
        chk($sformatf("rnd%0d_f_wb%0d_reg", t, k), 32'(wb_f[k].r), 32'(exp_wb[k].r));
        chk($sformatf("rnd%0d_f_wb%0d_data", t, k), wb_f[k].d, exp_wb[k].d);
      end
      if (k < wb_n.size()) begin
        chk($sformatf("rnd%0d_n_wb%0d_reg", t, k), 32'(wb_n[k].r), 32'(exp_wb[k].r));
        chk($sformatf("rnd%0d_n_wb%0d_data", t, k), wb_n[k].d, exp_wb[k].d);
      end
    end
    for (int k = 0; k < exp_st.size(); k++) begin
      if (k < st_f.size()) begin
        chk($sformatf("rnd%0d_f_st%0d_addr", t, k), st_f[k].a, exp_st[k].a);
        chk($sformatf("rnd%0d_f_st%0d_data", t, k), st_f[k].d, exp_st[k].d);
      end
      if (k < st_n.size()) begin
        chk($sformatf("rnd%0d_n_st%0d_addr", t, k), st_n[k].a, exp_st[k].a);
        chk($sformatf("rnd%0d_n_st%0d_data", t, k), st_n[k].d, exp_st[k].d);
      end
    end
  endtask

  int first12;

  initial begin
    // Forward chain program, also used for the reset sequence.
    clear_prog();
    prog[0] = enc_i(6'b001000, 5'd1, 5'd0, 16'd5);
    prog[1] = enc_i(6'b001000, 5'd2, 5'd1, 16'd3);
    prog[2] = enc_r(6'b100000, 5'd3, 5'd1, 5'd2);
    prog[3] = enc_r(6'b100010, 5'd4, 5'd3, 5'd1);
    run(10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_f_strobes", {27'd0, dwe_f, dre_f, wbwe_f, stl_f, fl_f}, 32'd0);
    chk("rst_n_strobes", {27'd0, dwe_n, dre_n, wbwe_n, stl_n, fl_n}, 32'd0);
    chk("rst_f_dmem_addr", da_f, 32'd0);
    chk("rst_f_dmem_wdata", dw_f, 32'd0);
    chk("rst_f_wb_reg", 32'(wbr_f), 32'd0);
    chk("rst_f_wb_data", wbd_f, 32'd0);
    chk("rst_f_imem_addr", ia_f, 32'h0000_0000);
    chk("rst_n_imem_addr", ia_n, 32'h0000_0000);
    @(posedge clk); #1;
    chk("rst2_f_imem_addr", ia_f, 32'h0000_0000);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_f_no_wb", 32'(wb_f.size()), 32'd0);
    chk("post_rst_n_no_wb", 32'(wb_n.size()), 32'd0);
    chk("first_fetch_pc", fetch_f[0], 32'h0000_0000);
    repeat (16) @(posedge clk); #1;

    chk("chain_f_count", 32'(wb_f.size()), 32'd4);
    if (wb_f.size() == 4) begin
      chk("chain_f_first_cycle", 32'(wb_f[0].c), 32'd4);
      chk("chain_f_d0", wb_f[0].d, 32'd5);
      chk("chain_f_d1", wb_f[1].d, 32'd8);
      chk("chain_f_d2", wb_f[2].d, 32'd13);
      chk("chain_f_d3", wb_f[3].d, 32'd8);
      chk("chain_f_r3", 32'(wb_f[3].r), 32'd4);
      chk("chain_f_consec", 32'(wb_f[3].c - wb_f[0].c), 32'd3);
    end
    chk("chain_f_stalls", 32'(stall_f_cnt), 32'd0);
    chk("chain_n_count", 32'(wb_n.size()), 32'd4);
    chk("chain_n_r3", last_wb(1, 5'd3), 32'd13);
    chk("chain_n_r4", last_wb(1, 5'd4), 32'd8);
    chk("chain_n_stalls", 32'(stall_n_cnt), 32'd6);

    // Load-use
    clear_prog();
    prog[0] = enc_i(6'b001000, 5'd1, 5'd0, 16'd7);
    prog[1] = enc_i(6'b101011, 5'd1, 5'd0, 16'd8);
    prog[2] = enc_i(6'b100011, 5'd4, 5'd0, 16'd8);
    prog[3] = enc_r(6'b100000, 5'd5, 5'd4, 5'd4);
    run(24);
    chk("lu_f_stalls", 32'(stall_f_cnt), 32'd1);
    chk("lu_f_stcount", 32'(st_f.size()), 32'd1);
    if (st_f.size() == 1) begin
      chk("lu_f_st_addr", st_f[0].a, 32'd8);
      chk("lu_f_st_data", st_f[0].d, 32'd7);
    end
    chk("lu_f_r5", last_wb(0, 5'd5), 32'd14);
    chk("lu_n_r5", last_wb(1, 5'd5), 32'd14);
    chk("lu_n_stcount", 32'(st_n.size()), 32'd1);

    // Taken beq
    clear_prog();
    prog[0] = enc_i(6'b000100, 5'd0, 5'd0, 16'd2);
    prog[1] = enc_i(6'b001000, 5'd6, 5'd0, 16'd1);
    prog[2] = enc_i(6'b001000, 5'd6, 5'd0, 16'd2);
    prog[3] = enc_i(6'b001000, 5'd7, 5'd0, 16'd1);
    run(16);
    chk("beq_f_flush", 32'(flush_f_cnt), 32'd1);
    chk("beq_n_flush", 32'(flush_n_cnt), 32'd1);
    chk("beq_f_r6_writes", 32'(count_wb(0, 5'd6)), 32'd0);
    chk("beq_n_r6_writes", 32'(count_wb(1, 5'd6)), 32'd0);
    chk("beq_f_r7", last_wb(0, 5'd7), 32'd1);
    first12 = -1;
    for (int k = 15; k >= 0; k--) if (fetch_f[k] == 32'd12) first12 = k;
    chk("beq_target_fetch_cycle", 32'(first12), 32'd3);

    // Jump
    clear_prog();
    prog[0]  = enc_j(32'h40);
    prog[1]  = enc_i(6'b001000, 5'd8, 5'd0, 16'd3);
    prog[16] = enc_i(6'b001000, 5'd10, 5'd0, 16'd4);
    run(14);
    chk("j_f_imem_addr", fetch_f[2], 32'h40);
    chk("j_f_flush", 32'(flush_f_cnt), 32'd1);
    chk("j_f_r8_writes", 32'(count_wb(0, 5'd8)), 32'd0);
    chk("j_n_r8_writes", 32'(count_wb(1, 5'd8)), 32'd0);
    chk("j_f_r10", last_wb(0, 5'd10), 32'd4);

    // Edge cases: write to $0, add of zeros, unknown opcode, signed slt
    clear_prog();
    prog[0] = enc_i(6'b001000, 5'd0, 5'd0, 16'd9);
    prog[1] = enc_r(6'b100000, 5'd9, 5'd0, 5'd0);
    prog[2] = 32'hFC21_0005;
    prog[3] = enc_i(6'b001000, 5'd1, 5'd0, 16'hFFFF);
    prog[4] = enc_i(6'b001000, 5'd2, 5'd0, 16'd1);
    prog[5] = enc_r(6'b101010, 5'd11, 5'd1, 5'd2);
    run(20);
    chk("edge_f_count", 32'(wb_f.size()), 32'd4);
    if (wb_f.size() == 4) begin
      chk("edge_f_first_reg", 32'(wb_f[0].r), 32'd9);
      chk("edge_f_first_data", wb_f[0].d, 32'd0);
      chk("edge_f_neg1", wb_f[1].d, 32'hFFFF_FFFF);
    end
    chk("edge_f_r0_writes", 32'(count_wb(0, 5'd0)), 32'd0);
    chk("edge_f_slt", last_wb(0, 5'd11), 32'd1);
    chk("edge_n_slt", last_wb(1, 5'd11), 32'd1);
    chk("edge_f_no_store", 32'(st_f.size()), 32'd0);

    // Random programs against the instruction-level model
    for (int t = 0; t < 6; t++) begin
      gen_random(24);
      model_run();
      run(160);
      cmp_random(t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
